digit_scan_controller: RTL and testbench
========================================

// Module: digit_scan_controller
// PURPOSE
//  Time-multiplexed anode scanner for N-digit 7-segment displays: cycles the
//  active digit, drives one-hot anodes and a digit select for the segment mux.
//  Adds a built-in refresh prescaler, PWM brightness, per-digit blanking and
//  enable/hold. Sits between the display data mux (consumes sel) and the pins.
// PARAMETERS
//  NUM_DIGITS  8        number of digits scanned, 2..16, need not be power of 2
//  SEL_W       3        select width, = $clog2(NUM_DIGITS)
//  BRIGHT_W    4        brightness code width; slot split into 2**BRIGHT_W phases
//  SUB_CYC     6250     clk cycles per PWM phase, >=1 (slot = SUB_CYC*2**BRIGHT_W)
//  AN_ACT_LOW  1        1: anode on = 0 (board default); 0: anode on = 1
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high
//  enable       in   1           1: scan runs; 0: freeze counters, all anodes off
//  digit_en     in   NUM_DIGITS  per-digit lit mask; 0 blanks that digit's slot
//  bright       in   BRIGHT_W    brightness; lit phases = bright+1 of 2**BRIGHT_W
//  a            out  NUM_DIGITS  registered one-hot anode drive (polarity per AN_ACT_LOW)
//  sel          out  SEL_W       registered index of digit currently owning the slot
//  slot_start   out  1           registered 1-cycle pulse, first cycle of each slot
//  frame_start  out  1           registered 1-cycle pulse, first cycle of slot 0
// BEHAVIOUR
//  - Reset (sync, on clk edge with reset=1): sub_cnt=0, phase=0, sel=0,
//    a=all-off (all 1s if AN_ACT_LOW), slot_start=0, frame_start=0. Reset wins
//    over every other input, including mid-slot.
//  - sub_cnt counts 0..SUB_CYC-1; at SUB_CYC-1 wraps to 0 and phase increments.
//  - phase counts 0..2**BRIGHT_W-1; at max with sub_cnt terminal: phase->0,
//    sel -> sel+1, or 0 when sel==NUM_DIGITS-1 (explicit compare, no natural wrap).
//  - Slot length fixed at SUB_CYC*2**BRIGHT_W cycles; disabled digits are NOT
//    skipped (constant refresh rate, sel still visits them).
//  - a, sel, pulses all registered from next-state in the same edge, so a and sel
//    are always consistent: at most one anode on, and only bit [sel].
//  - Anode [sel] on iff enable=1 & digit_en[sel]=1 & phase<=bright. bright=max
//    -> lit whole slot; bright=0 -> lit first phase only. bright/digit_en sampled
//    every cycle; changes take effect next edge.
//  - slot_start=1 on the cycle sel takes a new value (incl. wrap);
//    frame_start=1 same cycle when new sel==0. No pulses on reset release.
//  - First edge after reset with enable=1: sel=0, a lights digit 0 if enabled;
//    first slot_start occurs after one full slot.
//  - enable=0: sub_cnt, phase, sel hold; a=all-off; pulses 0. Re-assert resumes
//    from held count with no extra pulse.
//  - Arithmetic unsigned; phase<=bright compare at BRIGHT_W bits; sub_cnt width
//    $clog2(SUB_CYC) (min 1).
// STRUCTURE
//  - scan_pkg: AN_ON/AN_OFF polarity helpers, clog2 function, width constants.
//  - One sub-module: scan_prescaler (sub_cnt + phase, outputs phase, slot_tick,
//    hold on enable=0); parent holds sel, anode decode, output registers.
// TESTING (NUM_DIGITS=4, SEL_W=2, BRIGHT_W=2, SUB_CYC=2 -> 8-cycle slot)
//  - reset 3 cycles, enable=1, digit_en=4'hF, bright=3 -> a=1110,sel=0;
//    after 8 clks sel=1,a=1101,slot_start=1; after 32 clks sel=0,frame_start=1.
//  - bright=1 -> per slot a lit 4 clks (phases 0,1) then all-off 4 clks.
//  - digit_en=4'b1011 -> during sel=2 a=1111 for all 8 clks; sel still 2.
//  - enable=0 at sel=1 cycle 3 for 10 clks -> a=1111, sel=1 held, no pulses;
//    re-enable -> slot ends 5 clks later.
//  - reset pulse mid-slot at sel=3 -> next clk sel=0, a=1111, pulses 0.
//  - NUM_DIGITS=6, SEL_W=3: sel sequence 0..5,0; never 6/7; one-hot a checked.

Source files
------------

// File: rtl/digit_scan_controller_pkg.sv
// ============================================================================
//  Module  : digit_scan_controller_pkg
//  Brief   : Shared constants and helpers for the 7-segment digit scanner.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package digit_scan_controller_pkg;

   localparam int unsigned MAX_DIGITS = 16;

   // Counter width for a modulus, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   function automatic logic an_bit(input logic on, input logic act_low);
      return on ^ act_low;
   endfunction

   function automatic logic an_off(input logic act_low);
      return act_low;
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_scan_controller_if.sv
// ============================================================================
//  Module  : digit_scan_controller_if
//  Brief   : Control inputs and display drive outputs of the digit scanner.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface digit_scan_controller_if #(
   parameter int NUM_DIGITS = 8,
   parameter int SEL_W      = 3,
   parameter int BRIGHT_W   = 4
);
   logic                  enable;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [BRIGHT_W-1:0]   bright;
   logic [NUM_DIGITS-1:0] a;
   logic [SEL_W-1:0]      sel;
   logic                  slot_start;
   logic                  frame_start;

   modport master (
      output enable, digit_en, bright,
      input  a, sel, slot_start, frame_start
   );

   modport slave (
      input  enable, digit_en, bright,
      output a, sel, slot_start, frame_start
   );
endinterface

`default_nettype wire

// File: rtl/digit_scan_controller_prescaler.sv
// ============================================================================
//  Module  : digit_scan_controller_prescaler
//  Brief   : Refresh prescaler: sub-phase counter and PWM phase counter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_scan_controller_prescaler
   import digit_scan_controller_pkg::*;
#(
   parameter int BRIGHT_W = 4,
   parameter int SUB_CYC  = 6250
) (
   input  wire logic                clk,
   input  wire logic                reset,
   input  wire logic                enable_i,
   output logic [BRIGHT_W-1:0]      phase_nxt_o,
   output logic                     slot_tick_o
);
   localparam int unsigned         SUB_W      = clog2_min1(SUB_CYC);
   localparam logic [SUB_W-1:0]    SUB_LAST   = SUB_W'(SUB_CYC - 1);
   localparam logic [BRIGHT_W-1:0] PHASE_LAST = '1;

   logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
   logic [BRIGHT_W-1:0] phase_q, phase_d;
   logic                tick_d;

   always_comb begin
      sub_cnt_d = sub_cnt_q;
      phase_d   = phase_q;
      tick_d    = 1'b0;
      if (enable_i) begin
         if (sub_cnt_q == SUB_LAST) begin
            sub_cnt_d = '0;
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
               tick_d  = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sub_cnt_q <= '0;
         phase_q   <= '0;
      end else begin
         sub_cnt_q <= sub_cnt_d;
         phase_q   <= phase_d;
      end
   end

   // Next-state values so the parent can register outputs on the same edge.
   assign phase_nxt_o = phase_d;
   assign slot_tick_o = tick_d;

endmodule

`default_nettype wire

// File: rtl/digit_scan_controller.sv
// ============================================================================
//  Module  : digit_scan_controller
//  Brief   : Time-multiplexed anode scanner with PWM brightness and blanking.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_scan_controller
   import digit_scan_controller_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SEL_W      = 3,
   parameter int BRIGHT_W   = 4,
   parameter int SUB_CYC    = 6250,
   parameter int AN_ACT_LOW = 1
) (
   input wire logic                 clk,
   input wire logic                 reset,
   digit_scan_controller_if.slave   bus
);
   localparam logic                  ACT_LOW  = (AN_ACT_LOW != 0);
   localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{an_off(ACT_LOW)}};

   logic [BRIGHT_W-1:0]   phase_nxt;
   logic                  slot_tick;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [NUM_DIGITS-1:0] a_q, a_d;
   logic                  slot_start_q, frame_start_q;
   logic                  lit_d;

   digit_scan_controller_prescaler #(
      .BRIGHT_W (BRIGHT_W),
      .SUB_CYC  (SUB_CYC)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .enable_i    (bus.enable),
      .phase_nxt_o (phase_nxt),
      .slot_tick_o (slot_tick)
   );

   // Explicit wrap so non-power-of-two digit counts never visit unused codes.
   always_comb begin
      sel_d = sel_q;
      if (slot_tick) begin
         sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end
      lit_d = bus.enable & bus.digit_en[sel_d] & (phase_nxt <= bus.bright);
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_anode
      assign a_d[i] = an_bit(lit_d && (sel_d == SEL_W'(i)), ACT_LOW);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q         <= '0;
         a_q           <= AN_OFF;
         slot_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         sel_q         <= sel_d;
         a_q           <= a_d;
         slot_start_q  <= slot_tick;
         frame_start_q <= slot_tick && (sel_d == '0);
      end
   end

   assign bus.a           = a_q;
   assign bus.sel         = sel_q;
   assign bus.slot_start  = slot_start_q;
   assign bus.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_controller.sv
// ============================================================================
//  Module  : tb_digit_scan_controller
//  Brief   : Scoreboard bench for the digit scanner (4-digit and 6-digit builds).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_digit_scan_controller;

   localparam int SUB = 2;

   typedef struct packed {
      logic [3:0] a;
      logic [1:0] sel;
      logic       ss;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   digit_scan_controller_if #(.NUM_DIGITS(4), .SEL_W(2), .BRIGHT_W(2)) bus4 ();
   digit_scan_controller_if #(.NUM_DIGITS(6), .SEL_W(3), .BRIGHT_W(2)) bus6 ();

   digit_scan_controller #(
      .NUM_DIGITS(4), .SEL_W(2), .BRIGHT_W(2), .SUB_CYC(SUB), .AN_ACT_LOW(1)
   ) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave)
   );

   digit_scan_controller #(
      .NUM_DIGITS(6), .SEL_W(3), .BRIGHT_W(2), .SUB_CYC(SUB), .AN_ACT_LOW(1)
   ) dut6 (
      .clk(clk), .reset(reset), .bus(bus6.slave)
   );

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   m_sub, m_phase, m_sel;

   function automatic exp_t observed();
      return {bus4.a, bus4.sel, bus4.slot_start, bus4.frame_start};
   endfunction

   // Reference model: advances one clock using current inputs, queues the
   // expected post-edge outputs, then waits for the edge.
   task automatic drive_cycle();
      exp_t e;
      logic tick;
      tick = 1'b0;
      if (reset) begin
         m_sub = 0; m_phase = 0; m_sel = 0;
      end else if (bus4.enable) begin
         if (m_sub == SUB - 1) begin
            m_sub = 0;
            if (m_phase == 3) begin
               m_phase = 0;
               tick    = 1'b1;
            end else begin
               m_phase++;
            end
         end else begin
            m_sub++;
         end
      end
      if (tick) m_sel = (m_sel == 3) ? 0 : m_sel + 1;
      e.sel = 2'(m_sel);
      e.ss  = tick;
      e.fs  = tick && (m_sel == 0);
      if (!reset && bus4.enable && bus4.digit_en[m_sel] && (m_phase <= int'(bus4.bright)))
         e.a = ~(4'b0001 << m_sel);
      else
         e.a = 4'hF;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, got;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL reset cyc%0d: got %b expected %b", i, got, e);
         else n_pass++;
      end
      n_chk++;
      if (bus4.a !== 4'hF || bus4.sel !== 2'd0)
         $display("FAIL reset_state: got a=%b sel=%0d expected a=1111 sel=0", bus4.a, bus4.sel);
      else n_pass++;
   endtask

   task automatic test_scan();
      exp_t e, got;
      reset = 1'b0;
      bus4.enable = 1'b1; bus4.digit_en = 4'hF; bus4.bright = 2'd3;
      for (int i = 1; i <= 32; i++) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL scan cyc%0d: got %b expected %b", i, got, e);
         else n_pass++;
         if (i == 1) begin
            n_chk++;
            if (bus4.a !== 4'b1110 || bus4.sel !== 2'd0 || bus4.slot_start !== 1'b0)
               $display("FAIL scan_first: got a=%b sel=%0d ss=%b expected a=1110 sel=0 ss=0",
                        bus4.a, bus4.sel, bus4.slot_start);
            else n_pass++;
         end
         if (i == 8) begin
            n_chk++;
            if (bus4.a !== 4'b1101 || bus4.sel !== 2'd1 || bus4.slot_start !== 1'b1)
               $display("FAIL scan_slot1: got a=%b sel=%0d ss=%b expected a=1101 sel=1 ss=1",
                        bus4.a, bus4.sel, bus4.slot_start);
            else n_pass++;
         end
         if (i == 32) begin
            n_chk++;
            if (bus4.sel !== 2'd0 || bus4.frame_start !== 1'b1 || bus4.a !== 4'b1110)
               $display("FAIL scan_frame: got sel=%0d fs=%b a=%b expected sel=0 fs=1 a=1110",
                        bus4.sel, bus4.frame_start, bus4.a);
            else n_pass++;
         end
      end
   endtask

   task automatic test_brightness();
      exp_t e, got;
      int   lit;
      lit = 0;
      bus4.bright = 2'd1;
      for (int i = 0; i < 16; i++) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL bright cyc%0d: got %b expected %b", i, got, e);
         else n_pass++;
         if (bus4.a !== 4'hF) lit++;
      end
      n_chk++;
      if (lit != 8) $display("FAIL bright_duty: got %0d lit cycles expected 8", lit);
      else n_pass++;
      bus4.bright = 2'd3;
   endtask

   task automatic test_blanking();
      exp_t e, got;
      int   sel2, blank2;
      sel2 = 0; blank2 = 0;
      bus4.digit_en = 4'b1011;
      for (int i = 0; i < 32; i++) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL blank cyc%0d: got %b expected %b", i, got, e);
         else n_pass++;
         if (bus4.sel === 2'd2) begin
            sel2++;
            if (bus4.a === 4'hF) blank2++;
         end
      end
      n_chk++;
      if (sel2 != 8 || blank2 != 8)
         $display("FAIL blank_slot: got sel2=%0d blank=%0d expected 8/8", sel2, blank2);
      else n_pass++;
      bus4.digit_en = 4'hF;
   endtask

   task automatic test_enable_hold();
      exp_t e, got;
      int   n, pulses;
      n = 0; pulses = 0;
      while (!(m_sel == 1 && (m_phase * SUB + m_sub) == 3) && n < 64) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL hold_align cyc%0d: got %b expected %b", n, got, e);
         else n_pass++;
         n++;
      end
      bus4.enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL hold cyc%0d: got %b expected %b", i, got, e);
         else n_pass++;
         if (bus4.slot_start !== 1'b0 || bus4.frame_start !== 1'b0) pulses++;
      end
      n_chk++;
      if (bus4.a !== 4'hF || bus4.sel !== 2'd1 || pulses != 0)
         $display("FAIL hold_state: got a=%b sel=%0d pulses=%0d expected a=1111 sel=1 pulses=0",
                  bus4.a, bus4.sel, pulses);
      else n_pass++;
      bus4.enable = 1'b1;
      n = 0;
      do begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL resume cyc%0d: got %b expected %b", n, got, e);
         else n_pass++;
         n++;
      end while (bus4.slot_start !== 1'b1 && n < 20);
      n_chk++;
      if (n != 5) $display("FAIL resume_len: got %0d clks expected 5", n);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      exp_t e, got;
      int   n;
      n = 0;
      while (!(m_sel == 3 && (m_phase * SUB + m_sub) == 4) && n < 64) begin
         drive_cycle();
         e = sb.pop_front(); got = observed();
         n_chk++;
         if (got !== e) $display("FAIL rmid_align cyc%0d: got %b expected %b", n, got, e);
         else n_pass++;
         n++;
      end
      reset = 1'b1;
      drive_cycle();
      e = sb.pop_front(); got = observed();
      n_chk++;
      if (got !== e || got !== exp_t'({4'hF, 2'd0, 1'b0, 1'b0}))
         $display("FAIL rmid_reset: got %b expected %b", got, e);
      else n_pass++;
      reset = 1'b0;
      drive_cycle();
      e = sb.pop_front(); got = observed();
      n_chk++;
      if (got !== e || got !== exp_t'({4'b1110, 2'd0, 1'b0, 1'b0}))
         $display("FAIL rmid_release: got %b expected %b", got, e);
      else n_pass++;
   endtask

   task automatic test_six_digits();
      logic [5:0] exp_a;
      int         prev, wraps;
      prev  = int'(bus6.sel);
      wraps = 0;
      for (int i = 0; i < 120; i++) begin
         @(posedge clk);
         #1;
         exp_a = ~(6'b000001 << bus6.sel);
         n_chk++;
         if (bus6.sel > 3'd5 || bus6.a !== exp_a)
            $display("FAIL six_onehot cyc%0d: got sel=%0d a=%b expected sel<6 a=%b",
                     i, bus6.sel, bus6.a, exp_a);
         else n_pass++;
         if (bus6.slot_start === 1'b1) begin
            n_chk++;
            if (int'(bus6.sel) != ((prev == 5) ? 0 : prev + 1) ||
                bus6.frame_start !== (bus6.sel == 3'd0))
               $display("FAIL six_seq: got sel=%0d fs=%b after %0d", bus6.sel, bus6.frame_start, prev);
            else n_pass++;
            if (bus6.sel == 3'd0) wraps++;
            prev = int'(bus6.sel);
         end
      end
      n_chk++;
      if (wraps < 2) $display("FAIL six_wrap: got %0d wraps expected >=2", wraps);
      else n_pass++;
   endtask

   initial begin
      reset         = 1'b1;
      bus4.enable   = 1'b0;
      bus4.digit_en = 4'hF;
      bus4.bright   = 2'd3;
      bus6.enable   = 1'b1;
      bus6.digit_en = 6'h3F;
      bus6.bright   = 2'd3;
      m_sub = 0; m_phase = 0; m_sel = 0;
      @(negedge clk);
      test_reset();
      test_scan();
      test_brightness();
      test_blanking();
      test_enable_hold();
      test_reset_mid();
      test_six_digits();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
